// File: rtl/cache_access_master.sv
// cache_access_master: CPU-side requester that issues one load/store at a time to the cache port
module cache_access_master #(
    parameter int address_width = 10,
    parameter int WIDTH = 32,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_write,
    input  logic [address_width-1:0] req_addr,
    input  logic [WIDTH-1:0]         req_wdata,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic                     rsp_write,
    output logic [WIDTH-1:0]         rsp_rdata,
    output logic                     rsp_timeout,
    output logic [CNT_WIDTH-1:0]     rsp_stall_cycles,
    output logic [address_width-1:0] WordAddress,
    output logic [WIDTH-1:0]         DataIn,
    output logic                     mem_read,
    output logic                     mem_write,
    input  logic                     stall,
    input  logic [WIDTH-1:0]         DataOut
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} stateType;
    localparam logic [CNT_WIDTH-1:0] timeoutCount = CNT_WIDTH'(TIMEOUT_CYCLES);
    stateType state;
    logic op;
    logic [CNT_WIDTH-1:0] stallCount;
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            op <= 1'b0;
            stallCount <= '0;
            req_ready <= 1'b0;
            WordAddress <= '0;
            DataIn <= '0;
            mem_read <= 1'b0;
            mem_write <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_write <= 1'b0;
            rsp_rdata <= '0;
            rsp_timeout <= 1'b0;
            rsp_stall_cycles <= '0;
        end else begin
            case (state)
                IDLE: begin
                    req_ready <= 1'b1;
                    if (req_valid && req_ready) begin
                        state <= ISSUE;
                        req_ready <= 1'b0;
                        op <= req_write;
                        WordAddress <= req_addr;
                        DataIn <= req_wdata;
                        stallCount <= '0;
                        mem_read <= !req_write;
                        mem_write <= req_write;
                    end
                end
                ISSUE: begin
                    mem_read <= 1'b0;
                    mem_write <= 1'b0;
                    state <= WAIT;
                end
                WAIT: begin
                    if (!stall) begin
                        state <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_write <= op;
                        rsp_rdata <= op ? '0 : DataOut;
                        rsp_timeout <= 1'b0;
                        rsp_stall_cycles <= stallCount;
                    end else if (stallCount + 1'b1 == timeoutCount) begin
                        // abort: saturate the count and report no data
                        state <= RESP;
                        stallCount <= timeoutCount;
                        rsp_valid <= 1'b1;
                        rsp_write <= op;
                        rsp_rdata <= '0;
                        rsp_timeout <= 1'b1;
                        rsp_stall_cycles <= timeoutCount;
                    end else begin
                        stallCount <= stallCount + 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/cache_access_master.md
Name: cache_access_master

Overview:
- Processor-side initiator for the caching system's CPU port. It is the requester end of the WordAddress/DataIn/mem_read/mem_write/stall/DataOut interface.
- Accepts load/store commands on a valid/ready request channel and issues each one to the cache as a one-cycle mem_read or mem_write pulse.
- Holds address and data stable while the cache stalls, then returns read data, a stall-cycle count and a timeout flag on a valid/ready response channel.
- One transaction is outstanding at a time.

Parameters:
- address_width, 10, word-address width
- WIDTH, 32, data width
- TIMEOUT_CYCLES, 64, maximum stall cycles before abort (≥2)
- CNT_WIDTH, 8, width of stall counter/report; must hold TIMEOUT_CYCLES

Ports:
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-low reset
- req_valid  in  1  command present
- req_ready  out  1  master can accept command
- req_write  in  1  1=store, 0=load
- req_addr  in  address_width  word address
- req_wdata  in  WIDTH  store data
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_write  out  1  echo of req_write
- rsp_rdata  out  WIDTH  load data (0 for stores/timeouts)
- rsp_timeout  out  1  transaction aborted by timeout
- rsp_stall_cycles  out  CNT_WIDTH  stall-high cycles observed in WAIT
- WordAddress  out  address_width  to cache
- DataIn  out  WIDTH  to cache
- mem_read  out  1  to cache, one-cycle pulse
- mem_write  out  1  to cache, one-cycle pulse
- stall  in  1  from cache, miss/write-through in progress
- DataOut  in  WIDTH  from cache

Behaviour:
- All outputs are registered.
- Reset (reset=0 at a clock edge):
  - state=IDLE.
  - WordAddress, DataIn, mem_read, mem_write, rsp_* all 0; counter 0.
  - req_ready is 0 while reset is low and 1 in the first cycle after release.
  - A reset in any state aborts the transaction: no pulse, no response.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid&req_ready: latch addr/wdata/write into WordAddress/DataIn/op register, clear counter, go to ISSUE.
- ISSUE (exactly 1 cycle):
  - mem_read=~op or mem_write=op, held high for this cycle only.
  - req_ready=0. stall is ignored in this cycle.
  - Next state: WAIT.
- WAIT:
  - mem_read=mem_write=0. WordAddress/DataIn stay held unchanged.
  - stall=1: counter increments. If counter+1 == TIMEOUT_CYCLES, go to RESP with rsp_timeout=1, rsp_rdata=0, rsp_stall_cycles=TIMEOUT_CYCLES.
  - stall=0: transaction complete. Go to RESP with rsp_rdata=DataOut (load) or 0 (store), rsp_timeout=0, rsp_stall_cycles=counter.
  - A cache hit therefore completes in the first WAIT cycle.
- RESP:
  - rsp_valid=1; all rsp_* fields held stable until rsp_ready=1.
  - On handshake: rsp_valid drops next cycle, state=IDLE.
  - req_ready stays 0 throughout RESP.
- Latency, no stall:
  - accept edge → ISSUE cycle → WAIT cycle → rsp_valid asserted at the 3rd edge after accept.
  - Minimum back-to-back throughput is one transaction per 4 cycles.
- Counter saturates at TIMEOUT_CYCLES and never wraps.
- stall toggling 1→0→1 within WAIT: the first low sample completes the transaction.
- req_valid while not in IDLE is ignored, with no side effects.
- DataOut is sampled only on the completion edge.

Test Plan:
- Store addr=10'd1, data=32'd5, stall held 0 → mem_write high exactly 1 cycle with WordAddress=1, DataIn=5; rsp_valid 3 cycles after accept, rsp_write=1, rsp_rdata=0, rsp_stall_cycles=0, rsp_timeout=0.
- Load addr=10'd1, cache model raises stall for 3 cycles then DataOut=32'd5 → mem_read pulsed once; WordAddress=1 stable throughout; rsp_rdata=5, rsp_stall_cycles=3.
- TIMEOUT_CYCLES=16, stall stuck at 1 on a load → rsp_valid after 16 WAIT cycles, rsp_timeout=1, rsp_rdata=0, rsp_stall_cycles=16; req_ready returns to 1 after the handshake.
- Response back-pressure: rsp_ready=0 for 5 cycles after completion → rsp_* fields unchanged; req_ready=0 and a new req_valid is not accepted; accepted only after the rsp handshake.
- reset driven low during WAIT (stall=1) → the next edge gives all outputs 0 and no response ever issued; a fresh load of addr=10'd4 afterwards completes normally.
- Two back-to-back commands (store 10'd3=32'd10, then load 10'd3 returning 10), rsp_ready tied 1 → exactly two pulses 4 cycles apart with no overlap; responses delivered in order with correct data.
